adc128s_model: RTL and testbench

Behavioral/synthesizable model of a TI ADC128S 8-channel, 12-bit SPI A2D converter, used in system benches as the slave on the DUT's A2D SPI bus. It returns bench-programmable 12-bit values for the left load cell, right load cell and battery channels. Conversion results are pipelined: each 16-bit frame returns the channel addressed in the previous frame.

---
 rtl/adc128s_model.sv | 151 +++++++++++++++
 tb/tb_adc128s_model.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc128s_model.sv
// ---------------------------------------------------------------------------
// adc128s_model
//
// Purpose:
//   Model of a TI ADC128S 8-channel, 12-bit SPI A2D converter, used as the
//   SPI slave in system benches. Each 16-bit frame returns the conversion
//   result for the channel addressed in the previous frame. Three channels
//   return bench-programmable values. All other channels return zero.
//
// Parameters:
//   LFT_CH   - channel returning lft_cell_set  (default 3'd0)
//   RGHT_CH  - channel returning rght_cell_set (default 3'd4)
//   BATT_CH  - channel returning batt_set      (default 3'd5)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous reset, ACTIVE HIGH despite its name
//   SS_n           in   SPI slave select, active low
//   SCLK           in   SPI clock (mode 0)
//   MOSI           in   command bits from the master
//   MISO           out  conversion data to the master
//   batt_set       in   12-bit value for BATT_CH
//   lft_cell_set   in   12-bit value for LFT_CH
//   rght_cell_set  in   12-bit value for RGHT_CH
//
// Build option:
//   ADC128S_DITHER_EN - when defined, a 16-bit LFSR dithers the two LSBs of
//                       every returned value. It advances once per accepted
//                       frame.
// ---------------------------------------------------------------------------
module adc128s_model #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] batt_set,
    input  logic [11:0] lft_cell_set,
    input  logic [11:0] rght_cell_set
);

    // Bit [0] is the first synchronizer flop. Bit [1] is the synchronized
    // value. Bit [2] is the delayed copy used for edge detection.
    logic [2:0]  r_ssSync;
    logic [2:0]  r_sclkSync;
    logic [1:0]  r_mosiSync;

    logic [2:0]  r_addr;
    logic [15:0] r_tx;
    logic [15:0] r_rx;
    logic [4:0]  r_bitCnt;
    logic [15:0] r_frames;

    logic        w_ssFall;
    logic        w_ssRise;
    logic        w_ssLow;
    logic        w_sclkRise;
    logic        w_sclkFall;
    logic        w_frameOk;
    logic [11:0] w_sel;
    logic [11:0] w_txData;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ssSync   <= 3'b111;
            r_sclkSync <= 3'b000;
            r_mosiSync <= 2'b00;
        end else begin
            r_ssSync   <= {r_ssSync[1:0], SS_n};
            r_sclkSync <= {r_sclkSync[1:0], SCLK};
            r_mosiSync <= {r_mosiSync[0], MOSI};
        end
    end

    assign w_ssFall   =  r_ssSync[2] & ~r_ssSync[1];
    assign w_ssRise   = ~r_ssSync[2] &  r_ssSync[1];
    assign w_ssLow    = ~r_ssSync[1];
    assign w_sclkRise =  r_sclkSync[1] & ~r_sclkSync[2];
    assign w_sclkFall = ~r_sclkSync[1] &  r_sclkSync[2];
    assign w_frameOk  =  w_ssRise && (r_bitCnt == 5'd16);

    // Channel mux. If parameters collide, LFT wins over RGHT, and RGHT wins over BATT.
    always_comb begin
        w_sel = 12'h000;
        if (r_addr == LFT_CH)
            w_sel = lft_cell_set;
        else if (r_addr == RGHT_CH)
            w_sel = rght_cell_set;
        else if (r_addr == BATT_CH)
            w_sel = batt_set;
    end

`ifdef ADC128S_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsrFb;

    // Fibonacci taps 16,14,13,11, shifting towards bit 0.
    assign w_lfsrFb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk) begin
        if (rst_n)
            r_lfsr <= 16'hACE1;
        else if (w_frameOk)
            r_lfsr <= {w_lfsrFb, r_lfsr[15:1]};
    end

    assign w_txData = {w_sel[11:2], w_sel[1:0] ^ r_lfsr[1:0]};
`else
    assign w_txData = w_sel;
`endif

    // Frame engine. The result is captured into tx at SS_n fall, so any
    // change on *_set later in the frame does not disturb the data being
    // returned. SCLK edges are acted on only while SS_n is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_addr   <= 3'd0;
            r_tx     <= 16'h0000;
            r_rx     <= 16'h0000;
            r_bitCnt <= 5'd0;
            r_frames <= 16'h0000;
        end else if (w_ssFall) begin
            r_tx     <= {4'b0000, w_txData};
            r_rx     <= 16'h0000;
            r_bitCnt <= 5'd0;
        end else if (w_ssRise) begin
            if (w_frameOk) begin
                r_addr   <= r_rx[13:11];
                r_frames <= r_frames + 16'd1;
            end
        end else if (w_ssLow) begin
            if (w_sclkRise) begin
                r_rx <= {r_rx[14:0], r_mosiSync[1]};
                if (r_bitCnt != 5'd16)
                    r_bitCnt <= r_bitCnt + 5'd1;
            end else if (w_sclkFall) begin
                r_tx <= {r_tx[14:0], 1'b0};
            end
        end
    end

    // The delayed SS_n copy gates MISO. This keeps the output from
    // showing stale shift-register contents on the cycle before tx reloads.
    assign MISO = r_tx[15] & ~r_ssSync[2];

endmodule

// File: tb/tb_adc128s_model.sv
// ---------------------------------------------------------------------------
// tb_adc128s_model
//
// Purpose:
//   Self-checking bench for adc128s_model. It drives SPI frames with random
//   and directed commands. A behavioural model gives the expected word for
//   each frame. The model holds the last accepted channel and, when
//   ADC128S_DITHER_EN is defined, the dither LFSR.
//
// Ports: none (top-level bench).
// Build option: ADC128S_DITHER_EN mirrors the DUT option.
// ---------------------------------------------------------------------------
module tb_adc128s_model;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] batt_set;
    logic [11:0] lft_cell_set;
    logic [11:0] rght_cell_set;

    int vectors;
    int miscompares;

    // Reference model state: the channel the next frame will return, and the dither LFSR.
    logic [2:0]  mAddr;
    logic [15:0] mLfsr;

    adc128s_model dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SS_n         (SS_n),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .batt_set     (batt_set),
        .lft_cell_set (lft_cell_set),
        .rght_cell_set(rght_cell_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected 16-bit word for the channel the model currently holds.
    function automatic logic [15:0] expectWord();
        logic [11:0] v;
        v = 12'h000;
        case (mAddr)
            3'd0: v = lft_cell_set;
            3'd4: v = rght_cell_set;
            3'd5: v = batt_set;
            default: v = 12'h000;
        endcase
`ifdef ADC128S_DITHER_EN
        v = v ^ {10'd0, mLfsr[1:0]};
`endif
        return {4'h0, v};
    endfunction

    // Update the model after an accepted 16-bit frame. The LFSR uses
    // polynomial x^16+x^14+x^13+x^11.
    task automatic modelAccept(input logic [15:0] cmd);
        int fb;
        mAddr = cmd[13:11];
        fb = ((mLfsr >> 0) ^ (mLfsr >> 2) ^ (mLfsr >> 3) ^ (mLfsr >> 5)) & 1;
        mLfsr = (mLfsr >> 1) | 16'(fb << 15);
    endtask

    task automatic modelReset();
        mAddr = 3'd0;
        mLfsr = 16'hACE1;
    endtask

    // One SCLK period. MISO is sampled just before the rise, at least five
    // clocks after the previous fall or SS_n fall.
    task automatic sendBit(input logic b, output logic m);
        MOSI = b;
        m = MISO;
        SCLK = 1'b1;
        waitClk(5);
        SCLK = 1'b0;
        waitClk(5);
    endtask

    // Drive one frame with the given number of SCLK rises. midChange
    // rerandomizes the *_set inputs partway through the frame.
    task automatic runFrame(input logic [15:0] cmd, input int rises,
                            input bit midChange, output logic [15:0] got);
        logic m;
        got = 16'h0000;
        SS_n = 1'b0;
        waitClk(6);
        for (int i = 0; i < rises; i++) begin
            sendBit(cmd[15-i], m);
            got[15-i] = m;
            if (midChange && i == 7) begin
                batt_set      = 12'($urandom);
                lft_cell_set  = 12'($urandom);
                rght_cell_set = 12'($urandom);
            end
        end
        SS_n = 1'b1;
        waitClk(6);
    endtask

    task automatic doReset();
        rst_n = 1'b1;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        waitClk(4);
        rst_n = 1'b0;
        modelReset();
        waitClk(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        waitClk(4);
        vectors++;
        if (MISO !== 1'b0) begin
            $display("[TB] FAIL reset_miso: got %b expected 0", MISO);
            miscompares++;
        end
        rst_n = 1'b0;
        modelReset();
        waitClk(3);
        // SCLK toggling with SS_n high must be ignored.
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b1; waitClk(5);
            SCLK = 1'b0; waitClk(5);
        end
        vectors++;
        if (MISO !== 1'b0) begin
            $display("[TB] FAIL idle_miso: got %b expected 0", MISO);
            miscompares++;
        end
    endtask

    task automatic test_first_frame();
        logic [15:0] got, exp;
        lft_cell_set = 12'h3A5;
        exp = expectWord();
        runFrame(16'h0000, 16, 1'b0, got);
        modelAccept(16'h0000);
        vectors++;
        if (got !== exp) begin
            $display("[TB] FAIL first_frame: got %h expected %h", got, exp);
            miscompares++;
        end
    endtask

    task automatic test_batt();
        logic [15:0] got, exp;
        batt_set = 12'hFFF;
        exp = expectWord();
        runFrame(16'h2800, 16, 1'b0, got);
        modelAccept(16'h2800);
        vectors++;
        if (got !== exp) begin
            $display("[TB] FAIL batt_frameA: got %h expected %h", got, exp);
            miscompares++;
        end
        exp = expectWord();
        runFrame(16'h0000, 16, 1'b0, got);
        modelAccept(16'h0000);
        vectors++;
        if (got !== exp) begin
            $display("[TB] FAIL batt_frameB: got %h expected %h", got, exp);
            miscompares++;
        end
    endtask

    task automatic test_channels();
        logic [15:0] got, exp;
        logic [15:0] cmds [4];
        cmds[0] = 16'h2000;
        cmds[1] = 16'h0000;
        cmds[2] = 16'h0000;
        cmds[3] = 16'h3800;
        rght_cell_set = 12'h1C2;
        lft_cell_set  = 12'h5A6;
        for (int i = 0; i < 4; i++) begin
            exp = expectWord();
            runFrame(cmds[i], 16, 1'b0, got);
            modelAccept(cmds[i]);
            vectors++;
            if (got !== exp) begin
                $display("[TB] FAIL channel_seq%0d: got %h expected %h", i, got, exp);
                miscompares++;
            end
        end
        // The previous frame addressed channel 7, which returns zero.
        exp = expectWord();
        runFrame(16'h2000, 16, 1'b0, got);
        modelAccept(16'h2000);
        vectors++;
        if (got !== exp) begin
            $display("[TB] FAIL channel7: got %h expected %h", got, exp);
            miscompares++;
        end
    endtask

    task automatic test_abort();
        logic [15:0] got, exp;
        // The model now points at channel 4. Abort a ch5 command after nine rises.
        exp = expectWord();
        runFrame(16'h2800, 9, 1'b0, got);
        vectors++;
        if ((got & 16'hFF80) !== (exp & 16'hFF80)) begin
            $display("[TB] FAIL abort_prefix: got %h expected %h", got & 16'hFF80, exp & 16'hFF80);
            miscompares++;
        end
        exp = expectWord();
        runFrame(16'h0000, 16, 1'b0, got);
        modelAccept(16'h0000);
        vectors++;
        if (got !== exp) begin
            $display("[TB] FAIL after_abort: got %h expected %h", got, exp);
            miscompares++;
        end
    endtask

    task automatic test_midframe_reset();
        logic [15:0] got, exp;
        logic        m;
        batt_set = 12'hABC;
        exp = expectWord();
        runFrame(16'h2800, 16, 1'b0, got);
        modelAccept(16'h2800);
        vectors++;
        if (got !== exp) begin
            $display("[TB] FAIL pre_reset_frame: got %h expected %h", got, exp);
            miscompares++;
        end
        // Start a frame returning batt_set. Shift until MISO carries data, then reset.
        batt_set = 12'hFFF;
        SS_n = 1'b0;
        waitClk(6);
        for (int i = 0; i < 6; i++)
            sendBit(1'b0, m);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (MISO !== 1'b0) begin
            $display("[TB] FAIL reset_midframe_miso: got %b expected 0", MISO);
            miscompares++;
        end
        waitClk(3);
        rst_n = 1'b0;
        modelReset();
        waitClk(6);
        lft_cell_set = 12'h7E4;
        exp = expectWord();
        runFrame(16'h0000, 16, 1'b0, got);
        modelAccept(16'h0000);
        vectors++;
        if (got !== exp) begin
            $display("[TB] FAIL post_reset_frame: got %h expected %h", got, exp);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [15:0] got, exp, cmd, mask;
        int          rises;
        bit          midChange;
        for (int n = 0; n < 30; n++) begin
            cmd           = 16'($urandom);
            batt_set      = 12'($urandom);
            lft_cell_set  = 12'($urandom);
            rght_cell_set = 12'($urandom);
            rises         = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
            midChange     = ($urandom_range(0, 2) == 0);
            exp = expectWord();
            runFrame(cmd, rises, midChange, got);
            mask = 16'hFFFF << (16 - rises);
            if (rises == 16)
                modelAccept(cmd);
            vectors++;
            if ((got & mask) !== (exp & mask)) begin
                $display("[TB] FAIL random%0d: got %h expected %h (rises %0d)",
                         n, got & mask, exp & mask, rises);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        batt_set      = 12'h000;
        lft_cell_set  = 12'h000;
        rght_cell_set = 12'h000;
        modelReset();
        test_reset();
        test_first_frame();
        test_batt();
        test_channels();
        test_abort();
        test_midframe_reset();
        test_random();
        doReset();
        test_first_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
